secure_mem_ctrl: RTL

Single-requester access controller placed directly upstream of the secure key memory. It accepts valid/ready read and write requests, checks each against a locked-address policy, and issues one-cycle `rd_en`/`wr_en` strobes to the memory. It captures the registered read data and returns a held response with an error flag, and it counts policy violations. The integration drives the memory's active-low reset from `~rst`.

---
 rtl/secure_mem_pkg.sv | 6 +
 rtl/secure_mem_ctrl_if.sv | 12 +
 rtl/secure_mem_access_policy.sv | 20 ++
 rtl/secure_mem_ctrl.sv | 82 ++++++++
 4 files changed

// File: rtl/secure_mem_pkg.sv
// secure_mem_pkg: shared state encoding and defaults for the secure memory controller
package secure_mem_pkg;
  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP} smc_state_t;
  localparam logic [15:0] SMC_DEFAULT_LOCK_MASK = 16'h3C04;
  localparam int SMC_VIOL_W = 8;
endpackage

// File: rtl/secure_mem_ctrl_if.sv
// secure_mem_ctrl_if: request/response handshake bundle between requester and controller
interface secure_mem_ctrl_if #(parameter int WIDTH = 256, parameter int AW = 4);
  logic req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic rsp_valid, rsp_ready, rsp_err;
  logic [WIDTH-1:0] rsp_rdata;
  modport master (output req_valid, req_we, req_addr, req_wdata, rsp_ready,
                  input req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave (input req_valid, req_we, req_addr, req_wdata, rsp_ready,
                 output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/secure_mem_access_policy.sv
// secure_mem_access_policy: range and lock check; SECURE_MEM_RD_LOCK_EN also blocks locked reads
module secure_mem_access_policy #(
  parameter int LENGTH = 16,
  parameter logic [LENGTH-1:0] LOCK_MASK = secure_mem_pkg::SMC_DEFAULT_LOCK_MASK,
  localparam int AW = $clog2(LENGTH)
) (
  input  logic [AW-1:0] addr,
  input  logic          we,
  output logic          allow
);
`ifdef SECURE_MEM_RD_LOCK_EN
  localparam bit RD_LOCK = 1'b1;
`else
  localparam bit RD_LOCK = 1'b0;
`endif
  logic in_range, locked;
  assign in_range = {1'b0, addr} < (AW+1)'(LENGTH);
  assign locked = in_range && LOCK_MASK[addr];
  assign allow = in_range && !(locked && (we || RD_LOCK));
endmodule

// File: rtl/secure_mem_ctrl.sv
// secure_mem_ctrl: policy-checked access FSM in front of the key memory (SECURE_MEM_RD_LOCK_EN in policy)
module secure_mem_ctrl
  import secure_mem_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int LENGTH = 16,
  parameter logic [LENGTH-1:0] LOCK_MASK = SMC_DEFAULT_LOCK_MASK,
  localparam int AW = $clog2(LENGTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  secure_mem_ctrl_if.slave      bus,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [AW-1:0]         mem_addr,
  output logic [WIDTH-1:0]      mem_wrData,
  input  logic [WIDTH-1:0]      mem_rdData,
  input  logic                  mem_rdData_valid,
  output logic [SMC_VIOL_W-1:0] viol_cnt
);
  smc_state_t state;
  logic allow;
  secure_mem_access_policy #(.LENGTH(LENGTH), .LOCK_MASK(LOCK_MASK)) u_policy (
    .addr(bus.req_addr), .we(bus.req_we), .allow(allow)
  );
  assign bus.req_ready = (state == IDLE) && !rst;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_addr <= '0;
      mem_wrData <= '0;
      viol_cnt <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_wrData <= '0;
      case (state)
        IDLE: if (bus.req_valid) begin
          if (!allow) begin
            state <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err <= 1'b1;
            bus.rsp_rdata <= '0;
            if (viol_cnt != '1) viol_cnt <= viol_cnt + SMC_VIOL_W'(1);
          end else begin
            state <= bus.req_we ? WR_ISSUE : RD_ISSUE;
            mem_addr <= bus.req_addr;
            mem_rd_en <= !bus.req_we;
            mem_wr_en <= bus.req_we;
            mem_wrData <= bus.req_we ? bus.req_wdata : '0;
          end
        end
        RD_ISSUE: state <= RD_WAIT;
        // registered memory answers in this single cycle or the read is failed
        RD_WAIT: begin
          state <= RESP;
          bus.rsp_valid <= 1'b1;
          bus.rsp_err <= !mem_rdData_valid;
          bus.rsp_rdata <= mem_rdData_valid ? mem_rdData : '0;
        end
        WR_ISSUE: begin
          state <= RESP;
          bus.rsp_valid <= 1'b1;
          bus.rsp_err <= 1'b0;
          bus.rsp_rdata <= '0;
        end
        RESP: if (bus.rsp_ready) begin
          state <= IDLE;
          bus.rsp_valid <= 1'b0;
          bus.rsp_err <= 1'b0;
          bus.rsp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
